// File: rtl/axil_rr_arbiter.sv
// Purpose : two-requester round-robin arbiter feeding a single AXI-Lite master port.
// Latency : grant-to-done 4 cycles minimum (grant, addr/data, resp, done) with a zero-wait slave.
// Backpress: each requester holds req until done; slave READY/VALID stalls hold the FSM in place.
//
// Ports
//   clk, rst_n                 system clock (rising edge), asynchronous active-low reset
//   req_N, we_N, addr_N,       requester N (N = 0,1) transaction request and attributes;
//   wdata_N, wstrb_N           attributes must be stable while req_N is high
//   done_N, rdata_N, err_N     one-cycle completion pulse, read data, nonzero-response flag
//   M_AXI_*                    AXI-Lite master port (AW, W, B, AR, R channels)
module axil_rr_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    // requester 0
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [31:0]       wdata_0,
    input  logic [3:0]        wstrb_0,
    output logic              done_0,
    output logic [31:0]       rdata_0,
    output logic              err_0,

    // requester 1
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [31:0]       wdata_1,
    input  logic [3:0]        wstrb_1,
    output logic              done_1,
    output logic [31:0]       rdata_1,
    output logic              err_1,

    // AXI-Lite master: write address
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    // write data
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    // write response
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    // read address
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    // read data
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RRESP = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;

    // Owner of the current transaction and the requester served most recently.
    logic              gnt;
    logic              last;

    // Transaction attributes captured on the grant edge; the master port is
    // driven only from these so requester-side changes cannot leak through.
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    // ------------------------------------------------------------------
    // Grant selection (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic              any_req;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;

    assign any_req = req_0 | req_1;
    // On contention the requester that was not served last wins; otherwise
    // whichever one is asking.
    assign pick    = (req_0 & req_1) ? ~last : req_1;

    assign sel_we    = pick ? we_1    : we_0;
    assign sel_addr  = pick ? addr_1  : addr_0;
    assign sel_wdata = pick ? wdata_1 : wdata_0;
    assign sel_wstrb = pick ? wstrb_1 : wstrb_0;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic aw_hs;
    logic w_hs;
    logic aw_clear;
    logic w_clear;

    assign aw_hs    = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs     = M_AXI_WVALID  & M_AXI_WREADY;
    // A channel is finished once its VALID has already dropped or it
    // handshakes this cycle; AW and W may complete in either order.
    assign aw_clear = aw_hs | ~M_AXI_AWVALID;
    assign w_clear  = w_hs  | ~M_AXI_WVALID;

    // ------------------------------------------------------------------
    // Master address/data come straight from the capture registers
    // ------------------------------------------------------------------
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            last          <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            done_0        <= 1'b0;
            done_1        <= 1'b0;
            err_0         <= 1'b0;
            err_1         <= 1'b0;
            rdata_0       <= '0;
            rdata_1       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= pick;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        wstrb_q <= sel_wstrb;
                        if (sel_we) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= READ;
                        end
                    end
                end

                WRITE: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (aw_clear && w_clear) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WRESP;
                    end
                end

                WRESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        // Write completions update only the error flag; the
                        // requester's last read data is left untouched.
                        if (gnt) begin
                            err_1  <= (M_AXI_BRESP != 2'b00);
                            done_1 <= 1'b1;
                        end else begin
                            err_0  <= (M_AXI_BRESP != 2'b00);
                            done_0 <= 1'b1;
                        end
                        state <= DONE;
                    end
                end

                READ: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RRESP;
                    end
                end

                RRESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (gnt) begin
                            rdata_1 <= M_AXI_RDATA;
                            err_1   <= (M_AXI_RRESP != 2'b00);
                            done_1  <= 1'b1;
                        end else begin
                            rdata_0 <= M_AXI_RDATA;
                            err_0   <= (M_AXI_RRESP != 2'b00);
                            done_0  <= 1'b1;
                        end
                        state <= DONE;
                    end
                end

                DONE: begin
                    // done was raised on entry, so it is high for exactly
                    // this one cycle. Requests are not looked at here, which
                    // gives the other requester a fair shot next cycle.
                    done_0 <= 1'b0;
                    done_1 <= 1'b0;
                    last   <= gnt;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Purpose : directed self-checking bench for axil_rr_arbiter with a delay-programmable AXI-Lite slave.
// Latency : slave READY/VALID delays are set per step; zero delay gives same-cycle handshakes.
// Backpress: slave stalls via per-channel delay counters; bench waits are bounded by cycle budgets.
module tb_axil_rr_arbiter;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;

    logic              req_0, we_0, done_0, err_0;
    logic [ADDR_W-1:0] addr_0;
    logic [31:0]       wdata_0, rdata_0;
    logic [3:0]        wstrb_0;

    logic              req_1, we_1, done_1, err_1;
    logic [ADDR_W-1:0] addr_1;
    logic [31:0]       wdata_1, rdata_1;
    logic [3:0]        wstrb_1;

    logic [ADDR_W-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic              M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID, M_AXI_BREADY;
    logic              M_AXI_ARVALID, M_AXI_ARREADY;
    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID, M_AXI_RREADY;

    int tests = 0;
    int fails = 0;

    axil_rr_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .wstrb_0(wstrb_0),
        .done_0(done_0), .rdata_0(rdata_0), .err_0(err_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .wstrb_1(wstrb_1),
        .done_1(done_1), .rdata_1(rdata_1), .err_1(err_1),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // AXI-Lite slave model: 16-word memory, reset contents 0x1000_0000 + index
    // ------------------------------------------------------------------
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_v = 2'b00, rresp_v = 2'b00;

    logic [31:0] mem [16];
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_a, wd_q, rd_q;
    logic [3:0]  ws_q;

    logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
    logic [3:0]  wr_idx;
    logic [31:0] wr_dat, wr_old;
    logic [3:0]  wr_stb;

    assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_cnt >= aw_dly);
    assign M_AXI_WREADY  = M_AXI_WVALID  && !w_got  && (w_cnt  >= w_dly);
    assign M_AXI_BVALID  = b_pend && (b_cnt >= b_dly);
    assign M_AXI_BRESP   = M_AXI_BVALID ? bresp_v : 2'b00;
    assign M_AXI_ARREADY = M_AXI_ARVALID && !r_pend && (ar_cnt >= ar_dly);
    assign M_AXI_RVALID  = r_pend && (r_cnt >= r_dly);
    assign M_AXI_RDATA   = rd_q;
    assign M_AXI_RRESP   = M_AXI_RVALID ? rresp_v : 2'b00;

    assign s_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign s_w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
    assign s_b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
    assign s_ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign s_r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

    assign wr_idx = s_aw_hs ? M_AXI_AWADDR[5:2] : aw_a[5:2];
    assign wr_dat = s_w_hs  ? M_AXI_WDATA       : wd_q;
    assign wr_stb = s_w_hs  ? M_AXI_WSTRB       : ws_q;
    assign wr_old = mem[wr_idx];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_a <= '0; wd_q <= '0; ws_q <= '0; rd_q <= '0;
        end else begin
            if (s_aw_hs) begin
                aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; aw_cnt <= 0;
            end else if (M_AXI_AWVALID && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (s_w_hs) begin
                w_got <= 1'b1; wd_q <= M_AXI_WDATA; ws_q <= M_AXI_WSTRB; w_cnt <= 0;
            end else if (M_AXI_WVALID && !w_got) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !b_pend) begin
                b_pend <= 1'b1;
                b_cnt  <= 0;
                mem[wr_idx] <= {wr_stb[3] ? wr_dat[31:24] : wr_old[31:24],
                                wr_stb[2] ? wr_dat[23:16] : wr_old[23:16],
                                wr_stb[1] ? wr_dat[15:8]  : wr_old[15:8],
                                wr_stb[0] ? wr_dat[7:0]   : wr_old[7:0]};
            end
            if (s_b_hs) begin
                b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (b_pend) begin
                b_cnt <= b_cnt + 1;
            end
            if (s_ar_hs) begin
                r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0;
                rd_q   <= mem[M_AXI_ARADDR[5:2]];
            end else if (M_AXI_ARVALID && !r_pend) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (s_r_hs) begin
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Returns the number of falling edges until done_<which> is seen, -1 on timeout.
    task automatic wait_done(input int which, input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if ((which == 1) ? done_1 : done_0) begin
                cyc = i;
                break;
            end
        end
    endtask

    int          n_done;
    int          ord [3];
    int          dcyc [3];
    logic [31:0] drd [3];
    logic        both_seen;
    int          cyc;
    int          extra;

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        req_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; wdata_0 = '0; wstrb_0 = '0;
        req_1 = 1'b0; we_1 = 1'b0; addr_1 = '0; wdata_1 = '0; wstrb_1 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_awvalid", M_AXI_AWVALID, 1'b0);
        check("rst_wvalid",  M_AXI_WVALID,  1'b0);
        check("rst_bready",  M_AXI_BREADY,  1'b0);
        check("rst_arvalid", M_AXI_ARVALID, 1'b0);
        check("rst_rready",  M_AXI_RREADY,  1'b0);
        check("rst_done",    {done_0, done_1, err_0, err_1}, 4'b0000);
        check("rst_rdata",   {rdata_0, rdata_1}, 64'h0);

        // Both read requests present out of reset: 0, 1, 0 round-robin.
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h10;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'h14;
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        both_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done_0 && done_1) both_seen = 1'b1;
            if (done_0 || done_1) begin
                ord[n_done]  = done_1 ? 1 : 0;
                dcyc[n_done] = i;
                drd[n_done]  = done_1 ? rdata_1 : rdata_0;
                n_done++;
                if (n_done == 3) begin
                    req_0 = 1'b0;
                    req_1 = 1'b0;
                    break;
                end
            end
        end
        check("rr_count", n_done, 3);
        check("rr_order", {ord[0][1:0], ord[1][1:0], ord[2][1:0]}, 6'b00_01_00);
        check("rr_cycles", {dcyc[0][7:0], dcyc[1][7:0], dcyc[2][7:0]}, 24'h03_07_0B);
        check("rr_no_overlap", both_seen, 1'b0);
        check("rr_rdata", {drd[0], drd[1]}, {32'h1000_0004, 32'h1000_0005});
        check("rr_rdata_third", drd[2], 32'h1000_0004);
        check("rr_err", {err_0, err_1}, 2'b00);
        @(negedge clk);

        // Zero-wait write from requester 0: AW and W handshake together.
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'h0; wdata_0 = 32'hA5; wstrb_0 = 4'hF;
        @(negedge clk);
        check("wr_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWREADY, M_AXI_WREADY}, 4'b1111);
        check("wr_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, {32'h0, 32'hA5});
        @(negedge clk);
        check("wr_resp_phase", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_BVALID}, 4'b0011);
        @(negedge clk);
        check("wr_done", {done_0, done_1, err_0}, 3'b100);
        check("wr_rdata_kept", rdata_0, 32'h1000_0004);
        req_0 = 1'b0; we_0 = 1'b0;
        @(negedge clk);
        check("wr_done_pulse", done_0, 1'b0);
        check("wr_slave_mem", mem[0], 32'h0000_00A5);

        // AWREADY 3 cycles after WREADY: WVALID drops, AWVALID held.
        aw_dly = 3;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'h8; wdata_0 = 32'h1234_5678; wstrb_0 = 4'hF;
        @(negedge clk);
        check("awdly_c1", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWREADY, M_AXI_WREADY}, 4'b1101);
        @(negedge clk);
        check("awdly_c2", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b10);
        @(negedge clk);
        check("awdly_c3", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWREADY}, 3'b100);
        @(negedge clk);
        check("awdly_c4", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWREADY}, 3'b101);
        @(negedge clk);
        check("awdly_c5", {M_AXI_AWVALID, M_AXI_BREADY, done_0}, 3'b010);
        @(negedge clk);
        check("awdly_done", done_0, 1'b1);
        req_0 = 1'b0; we_0 = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_0 || done_1) extra++;
        end
        check("awdly_single_done", extra, 0);
        check("awdly_slave_mem", mem[2], 32'h1234_5678);
        aw_dly = 0;

        // Requester 1 write, then a slow erroring read of the same word.
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'h20; wdata_1 = 32'h0000_00A5; wstrb_1 = 4'hF;
        wait_done(1, 20, cyc);
        check("w1_latency", cyc, 3);
        check("w1_err_rdata", {err_1, rdata_1}, {1'b0, 32'h1000_0005});
        req_1 = 1'b0; we_1 = 1'b0;
        @(negedge clk);
        r_dly = 5; rresp_v = 2'b10;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'h20;
        wait_done(1, 30, cyc);
        check("rdly_latency", cyc, 8);
        check("rdly_result", {err_1, rdata_1}, {1'b1, 32'h0000_00A5});
        req_1 = 1'b0;
        @(negedge clk);
        check("rdly_hold", {done_1, err_1, rdata_1}, {1'b0, 1'b1, 32'h0000_00A5});
        r_dly = 0; rresp_v = 2'b00;

        // Reset asserted while waiting for the write response.
        b_dly = 10;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'h4; wdata_0 = 32'h77; wstrb_0 = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rst_wresp_bready", {M_AXI_BREADY, M_AXI_BVALID}, 2'b10);
        rst_n = 1'b0;
        req_0 = 1'b0; we_0 = 1'b0;
        b_dly = 0;
        #1;
        check("rst_async_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                   M_AXI_ARVALID, M_AXI_RREADY}, 5'b00000);
        @(negedge clk);
        check("rst_wresp_outs", {done_0, done_1, err_0, err_1}, 4'b0000);
        check("rst_wresp_rdata", {rdata_0, rdata_1}, 64'h0);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_0 || done_1 || M_AXI_AWVALID || M_AXI_ARVALID) extra++;
        end
        check("rst_no_done", extra, 0);
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'h4;
        wait_done(1, 20, cyc);
        check("post_rst_latency", cyc, 3);
        check("post_rst_rdata", {err_1, rdata_1}, {1'b0, 32'h1000_0001});
        req_1 = 1'b0;
        @(negedge clk);

        // Requester changes its address after grant: master keeps the latched one.
        ar_dly = 2;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h0C;
        @(negedge clk);
        check("latch_araddr_c1", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 32'h0C});
        addr_0 = 32'hFC;
        @(negedge clk);
        check("latch_araddr_c2", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 32'h0C});
        wait_done(0, 20, cyc);
        check("latch_latency", cyc, 3);
        check("latch_rdata", rdata_0, 32'h1000_0003);
        req_0 = 1'b0;
        ar_dly = 0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
